// File: rtl/ds_pwm_monitor.sv
`default_nettype none
// ============================================================================
// Module  : ds_pwm_monitor
// Purpose : Measures per-phase PWM high time between consecutive trigger
//           pulses and flags phases that toggled more than once in a window.
//           Declares a timeout when triggers stop arriving.
// Ports   : clk            - sole clock, rising edge
//           reset          - asynchronous, active-high
//           trigger        - one-cycle pulse at each PWM half-period boundary
//           pwm_in[2:0]    - sensed PWM {w, v, u}, asynchronous to clk
//           capture_valid  - one-cycle pulse, capture_* fields just updated
//           capture_data   - high-time counts packed {u, v, w}
//           capture_glitch - per phase {w, v, u}: >1 transition in window
//           timeout        - high while no trigger seen within TIMEOUT_CYCLES
// Revision: 1.0 - initial release
// ============================================================================
module ds_pwm_monitor #(
    parameter int PERIOD         = 3000,
    parameter int DATA_WIDTH     = 16,
    parameter int SYNC_STAGES    = 2,
    parameter int TIMEOUT_CYCLES = 2 * PERIOD
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    trigger,
    input  logic [2:0]              pwm_in,
    output logic                    capture_valid,
    output logic [3*DATA_WIDTH-1:0] capture_data,
    output logic [2:0]              capture_glitch,
    output logic                    timeout
);

    localparam int                    c_LEN_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_LEN_W-1:0]    c_LEN_MAX  = c_LEN_W'(TIMEOUT_CYCLES);
    localparam logic [DATA_WIDTH-1:0] c_HIGH_MAX = '1;

    // Elaboration-time sanity check on the parameter set.
    if (SYNC_STAGES < 2 || PERIOD < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("ds_pwm_monitor: SYNC_STAGES must be >= 2, PERIOD and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_TIMEOUT = 2'd2
    } state_t;

    state_t                         r_state;
    state_t                         w_state_next;
    logic [SYNC_STAGES-1:0][2:0]    r_sync;
    logic [2:0]                     r_prev;
    logic [2:0]                     w_sample;
    logic [2:0]                     w_edge;
    logic [2:0][DATA_WIDTH-1:0]     r_high;
    logic [2:0][1:0]                r_trans;
    logic [c_LEN_W-1:0]             r_len;
    logic                           w_open;
    logic                           w_count;
    logic                           w_capture;
    logic                           r_cap_valid;
    logic [3*DATA_WIDTH-1:0]        r_cap_data;
    logic [2:0]                     r_cap_glitch;
    logic                           r_timeout;

    // ------------------------------------------------------------------
    // Input synchronizer; the last stage is the sample used everywhere.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
            r_prev <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], pwm_in};
            r_prev <= w_sample;
        end
    end

    assign w_sample = r_sync[SYNC_STAGES-1];
    assign w_edge   = w_sample ^ r_prev;

    // ------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // w_open   : seed a fresh window from the current (trigger) cycle
    // w_count  : accumulate the current cycle into the open window
    // w_capture: publish the window that ends just before this cycle
    always_comb begin
        w_state_next = r_state;
        w_open       = 1'b0;
        w_count      = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (trigger) begin
                    w_state_next = ST_RUN;
                    w_open       = 1'b1;
                end
            end
            ST_RUN: begin
                if (trigger) begin
                    // A trigger on the threshold cycle still captures.
                    w_capture = 1'b1;
                    w_open    = 1'b1;
                end else begin
                    w_count = 1'b1;
                    if (r_len == c_LEN_MAX) begin
                        w_state_next = ST_TIMEOUT;
                    end
                end
            end
            ST_TIMEOUT: begin
                // The interrupted window is discarded, not captured.
                if (trigger) begin
                    w_state_next = ST_RUN;
                    w_open       = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Window counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_high  <= '0;
            r_trans <= '0;
            r_len   <= '0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (w_open) begin
                    r_high[i]  <= DATA_WIDTH'(w_sample[i]);
                    r_trans[i] <= {1'b0, w_edge[i]};
                end else if (w_count) begin
                    if (w_sample[i] && (r_high[i] != c_HIGH_MAX)) begin
                        r_high[i] <= r_high[i] + 1'b1;
                    end
                    if (w_edge[i] && (r_trans[i] != 2'd3)) begin
                        r_trans[i] <= r_trans[i] + 1'b1;
                    end
                end else if (r_state == ST_IDLE) begin
                    r_high[i]  <= '0;
                    r_trans[i] <= '0;
                end
            end

            if (w_open) begin
                r_len <= c_LEN_W'(1);
            end else if (w_count) begin
                if (r_len != c_LEN_MAX) begin
                    r_len <= r_len + 1'b1;
                end
            end else if (r_state == ST_IDLE) begin
                r_len <= '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Capture registers; only reset clears them.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cap_valid  <= 1'b0;
            r_cap_data   <= '0;
            r_cap_glitch <= '0;
            r_timeout    <= 1'b0;
        end else begin
            r_cap_valid <= w_capture;
            r_timeout   <= (w_state_next == ST_TIMEOUT);
            if (w_capture) begin
                r_cap_data   <= {r_high[0], r_high[1], r_high[2]};
                // count > 1 is exactly "bit 1 set" for a 2-bit counter
                r_cap_glitch <= {r_trans[2][1], r_trans[1][1], r_trans[0][1]};
            end
        end
    end

    assign capture_valid  = r_cap_valid;
    assign capture_data   = r_cap_data;
    assign capture_glitch = r_cap_glitch;
    assign timeout        = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_ds_pwm_monitor.sv
`default_nettype none
// ============================================================================
// Module  : tb_ds_pwm_monitor
// Purpose : Directed self-checking bench for ds_pwm_monitor. A window-level
//           model recomputes each capture from the recorded sample history,
//           and hand-computed literals pin the key results.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_ds_pwm_monitor;

    localparam int PERIOD = 3000;
    localparam int DW     = 16;
    localparam int SYNC   = 2;
    localparam int TMO    = 2 * PERIOD;
    localparam int HMAX   = 40000;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           trigger = 1'b0;
    logic [2:0]     pwm_in = 3'b000;
    logic           capture_valid;
    logic [3*DW-1:0] capture_data;
    logic [2:0]     capture_glitch;
    logic           timeout;

    ds_pwm_monitor #(
        .PERIOD        (PERIOD),
        .DATA_WIDTH    (DW),
        .SYNC_STAGES   (SYNC),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .trigger       (trigger),
        .pwm_in        (pwm_in),
        .capture_valid (capture_valid),
        .capture_data  (capture_data),
        .capture_glitch(capture_glitch),
        .timeout       (timeout)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int n_print = 0;

    // ------------------------------------------------------------------
    // Model: record inputs per cycle, rebuild each window retrospectively.
    // ------------------------------------------------------------------
    logic [2:0]      pwm_hist [HMAX];
    logic            rst_hist [HMAX];
    int              cyc    = 0;
    int              mode   = 0;   // 0 idle, 1 measuring, 2 timed out
    int              wstart = 0;
    logic            e_valid   = 1'b0;
    logic [3*DW-1:0] e_data    = '0;
    logic [2:0]      e_glitch  = '0;
    logic            e_timeout = 1'b0;

    // Synchronized sample seen during cycle c: the pwm_in of SYNC cycles
    // earlier, or 0 if any intervening edge was under reset.
    function automatic logic [2:0] samp(input int c);
        if (c < SYNC) return 3'b000;
        for (int k = c - SYNC; k < c; k++) begin
            if (rst_hist[k]) return 3'b000;
        end
        return pwm_hist[c - SYNC];
    endfunction

    function automatic logic [2:0] prevs(input int c);
        if (c < 1) return 3'b000;
        if (rst_hist[c-1]) return 3'b000;
        return samp(c - 1);
    endfunction

    task automatic capture_window(input int s, input int e);
        int hi [3];
        int tr [3];
        logic [2:0] sv;
        logic [2:0] pv;
        for (int p = 0; p < 3; p++) begin
            hi[p] = 0;
            tr[p] = 0;
        end
        for (int c = s; c < e; c++) begin
            sv = samp(c);
            pv = prevs(c);
            for (int p = 0; p < 3; p++) begin
                if (sv[p]) hi[p]++;
                if (sv[p] != pv[p]) tr[p]++;
            end
        end
        for (int p = 0; p < 3; p++) begin
            if (hi[p] > (1 << DW) - 1) hi[p] = (1 << DW) - 1;
        end
        e_data   = {DW'(hi[0]), DW'(hi[1]), DW'(hi[2])};
        e_glitch = {tr[2] > 1, tr[1] > 1, tr[0] > 1};
    endtask

    always @(posedge clk) begin
        if (cyc < HMAX) begin
            pwm_hist[cyc] = pwm_in;
            rst_hist[cyc] = reset;
            if (reset) begin
                mode      = 0;
                e_valid   = 1'b0;
                e_data    = '0;
                e_glitch  = '0;
                e_timeout = 1'b0;
            end else begin
                e_valid = 1'b0;
                case (mode)
                    0: if (trigger) begin
                        mode   = 1;
                        wstart = cyc;
                    end
                    1: if (trigger) begin
                        capture_window(wstart, cyc);
                        e_valid = 1'b1;
                        wstart  = cyc;
                    end else if (cyc - wstart >= TMO) begin
                        mode      = 2;
                        e_timeout = 1'b1;
                    end
                    default: if (trigger) begin
                        mode      = 1;
                        wstart    = cyc;
                        e_timeout = 1'b0;
                    end
                endcase
            end
            cyc++;
        end
    end

    // ------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------
    task automatic model_compare();
        logic            xv;
        logic [3*DW-1:0] xd;
        logic [2:0]      xg;
        logic            xt;
        xv = reset ? 1'b0 : e_valid;
        xd = reset ? '0   : e_data;
        xg = reset ? '0   : e_glitch;
        xt = reset ? 1'b0 : e_timeout;
        n_tests++;
        if ({capture_valid, capture_data, capture_glitch, timeout} !== {xv, xd, xg, xt}) begin
            n_fail++;
            if (n_print < 20) begin
                $display("FAIL model_cycle_%0d: got v=%b d=%h g=%b t=%b, expected v=%b d=%h g=%b t=%b",
                         cyc, capture_valid, capture_data, capture_glitch, timeout, xv, xd, xg, xt);
            end
            n_print++;
        end
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Inputs change at the falling edge; outputs are checked there too.
    task automatic drive(input logic t, input logic [2:0] p);
        trigger = t;
        pwm_in  = p;
        @(negedge clk);
        model_compare();
    endtask

    // Drive window cycles k0..k1-1; trigger on k==0. u has two ranges.
    task automatic seg(input int k0, input int k1,
                       input int u0, input int u1, input int u2, input int u3,
                       input int v0, input int v1, input int w0, input int w1);
        logic [2:0] p;
        for (int k = k0; k < k1; k++) begin
            p[0] = (k >= u0 && k < u1) || (k >= u2 && k < u3);
            p[1] = (k >= v0 && k < v1);
            p[2] = (k >= w0 && k < w1);
            drive(k == 0, p);
        end
    endtask

    initial begin
        @(negedge clk);
        repeat (3) drive(1'b0, 3'b000);
        check("reset_valid",   64'(capture_valid),  64'd0);
        check("reset_data",    64'(capture_data),   64'd0);
        check("reset_glitch",  64'(capture_glitch), 64'd0);
        check("reset_timeout", 64'(timeout),        64'd0);
        reset = 1'b0;
        repeat (5) drive(1'b0, 3'b000);

        // Window A: u rises late and falls on the next trigger, w likewise.
        seg(0, 1, 1998, 2998, 0, 0, 0, 0, 18, 2998);
        check("first_trigger_no_capture", 64'(capture_valid), 64'd0);
        seg(1, PERIOD, 1998, 2998, 0, 0, 0, 0, 18, 2998);

        // Window B: two 10-cycle u pulses.
        seg(0, 1, 100, 110, 200, 210, 0, 0, 0, 0);
        check("capA_valid",  64'(capture_valid),  64'd1);
        check("capA_data",   64'(capture_data),   64'({16'd1000, 16'd0, 16'd2980}));
        check("capA_glitch", 64'(capture_glitch), 64'b000);
        seg(1, PERIOD, 100, 110, 200, 210, 0, 0, 0, 0);

        // Window C: single clean rise on u.
        seg(0, 1, 2490, 2998, 0, 0, 0, 0, 0, 0);
        check("capB_valid",  64'(capture_valid),  64'd1);
        check("capB_data",   64'(capture_data),   64'({16'd20, 16'd0, 16'd0}));
        check("capB_glitch", 64'(capture_glitch), 64'b001);
        seg(1, PERIOD, 2490, 2998, 0, 0, 0, 0, 0, 0);

        // Window D: triggers stop.
        seg(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
        check("capC_data",   64'(capture_data),   64'({16'd508, 16'd0, 16'd0}));
        check("capC_glitch", 64'(capture_glitch), 64'b000);
        seg(1, TMO, 0, 0, 0, 0, 0, 0, 0, 0);
        check("timeout_before_threshold", 64'(timeout), 64'd0);
        drive(1'b0, 3'b000);
        check("timeout_at_threshold", 64'(timeout), 64'd1);
        repeat (20) drive(1'b0, 3'b000);
        check("timeout_held", 64'(timeout), 64'd1);

        // Window E: trigger out of timeout discards the window.
        seg(0, 1, 10, 20, 0, 0, 0, 0, 0, 0);
        check("recover_timeout", 64'(timeout),       64'd0);
        check("recover_no_valid", 64'(capture_valid), 64'd0);
        check("recover_data_held", 64'(capture_data), 64'({16'd508, 16'd0, 16'd0}));
        seg(1, PERIOD, 10, 20, 0, 0, 0, 0, 0, 0);

        // Window F: exactly TMO cycles long.
        seg(0, 1, 0, 0, 0, 0, 0, 0, 0, TMO);
        check("capE_valid",  64'(capture_valid),  64'd1);
        check("capE_data",   64'(capture_data),   64'({16'd10, 16'd0, 16'd0}));
        check("capE_glitch", 64'(capture_glitch), 64'b001);
        seg(1, TMO, 0, 0, 0, 0, 0, 0, 0, TMO);

        // Window G: trigger on the threshold cycle wins.
        seg(0, 1, 0, 200, 0, 0, 0, 200, 0, 200);
        check("capF_valid",   64'(capture_valid), 64'd1);
        check("capF_timeout", 64'(timeout),       64'd0);
        check("capF_data",    64'(capture_data),  64'({16'd0, 16'd0, 16'd5998}));
        seg(1, 100, 0, 200, 0, 0, 0, 200, 0, 200);

        // Asynchronous reset mid-window with all phases high.
        #1 reset = 1'b1;
        #1;
        check("async_rst_valid",   64'(capture_valid),  64'd0);
        check("async_rst_data",    64'(capture_data),   64'd0);
        check("async_rst_glitch",  64'(capture_glitch), 64'd0);
        check("async_rst_timeout", 64'(timeout),        64'd0);
        repeat (3) drive(1'b0, 3'b111);
        reset = 1'b0;
        repeat (10) drive(1'b0, 3'b111);
        seg(0, 1, 0, 99999, 0, 0, 0, 99999, 0, 99999);
        check("post_rst_no_capture", 64'(capture_valid), 64'd0);
        seg(1, PERIOD, 0, 99999, 0, 0, 0, 99999, 0, 99999);
        seg(0, 1, 0, 99999, 0, 0, 0, 99999, 0, 99999);
        check("capH_valid",  64'(capture_valid),  64'd1);
        check("capH_data",   64'(capture_data),   64'({16'd3000, 16'd3000, 16'd3000}));
        check("capH_glitch", 64'(capture_glitch), 64'b000);
        repeat (5) drive(1'b0, 3'b111);
        check("capH_valid_one_cycle", 64'(capture_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ds_pwm_monitor.md
DS_PWM_MONITOR -- requirements
Module: ds_pwm_monitor

Interface
REQ-001 SHALL have parameter PERIOD, default 3000, nominal cycles between consecutive trigger pulses.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, width of each per-phase measurement field.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, flip-flop stages in the input synchronizer (minimum 2).
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 2*PERIOD, window length that declares a missing trigger.
REQ-005 SHALL use one clock and an asynchronous, active-high reset.
REQ-006 Port list:
- clk  input  1  sole clock; all state on rising edge.
- reset  input  1  asynchronous, active-high.
- trigger  input  1  one-cycle pulse marking a PWM half-period boundary.
- pwm_in  input  3  sensed driver PWM, bit0=u, bit1=v, bit2=w; asynchronous to clk.
- capture_valid  output  1  one-cycle pulse; capture_* fields are new.
- capture_data  output  3*DATA_WIDTH  high-time cycle counts packed {u, v, w}, u in the MSB field.
- capture_glitch  output  3  per phase {w, v, u}: more than one transition in the window.
- timeout  output  1  high while no trigger has arrived within TIMEOUT_CYCLES.

Function
REQ-007 Each pwm_in bit SHALL pass through SYNC_STAGES flip-flops, all reset to 0; "sample" below means the synchronizer output.
REQ-008 A window SHALL span from a trigger cycle (inclusive) to the next trigger cycle (exclusive).
REQ-009 State machine SHALL have three states, IDLE (after reset), RUN and TIMEOUT.
REQ-010 IDLE: counters cleared, no capture; on trigger go to RUN and open a window; no capture_valid on this trigger.
REQ-011 RUN: on each cycle, per phase, high-count increments when sample=1, saturating at 2^DATA_WIDTH-1.
REQ-012 RUN: per phase, transition count increments when sample differs from the previous cycle's sample, saturating at 3.
REQ-013 RUN: window-length counter increments each cycle, saturating at TIMEOUT_CYCLES.
REQ-014 RUN + trigger: on the next clock edge, capture_data SHALL take the high-counts accumulated before the trigger cycle.
REQ-015 RUN + trigger: capture_glitch[i] SHALL take (transition count[i] > 1) on the same edge.
REQ-016 RUN + trigger: capture_valid SHALL pulse high for exactly one cycle on the same edge (latency one cycle after trigger).
REQ-017 The trigger cycle's own sample and transition SHALL seed the new window: high-count = sample, transition count = (transition ? 1 : 0), length = 1.
REQ-018 RUN, no trigger, window length reaching TIMEOUT_CYCLES: go to TIMEOUT and assert timeout on the next edge.
REQ-019 Trigger and the timeout threshold in the same cycle: trigger wins; normal capture; no timeout.
REQ-020 TIMEOUT: counters held; timeout stays 1; no capture_valid.
REQ-021 TIMEOUT + trigger: clear timeout, go to RUN, open a new window per REQ-017, no capture_valid (incomplete window discarded).
REQ-022 capture_data and capture_glitch SHALL hold their value between captures.
REQ-023 Arithmetic SHALL be unsigned; the window-length counter SHALL be $clog2(TIMEOUT_CYCLES+1) bits wide.

Reset
REQ-024 Reset assertion SHALL immediately force state IDLE and capture_valid=0, capture_data=0, capture_glitch=0, timeout=0, with synchronizer and all counters cleared.
REQ-025 Reset mid-window SHALL discard the partial window; the first trigger after release produces no capture.
REQ-026 Only reset clears outputs; trigger never does.

Verification
REQ-027 Defaults; trigger every 3000 cycles; u high for 1000 cycles, v for 0, w for 2980, each pulse fully inside the window -> capture_valid one cycle after the second trigger with capture_data={1000, 0, 2980}, capture_glitch=000.
REQ-028 First trigger after reset -> no capture_valid; second trigger -> capture_valid.
REQ-029 u with two 10-cycle pulses in one window -> capture u=20, capture_glitch[0]=1; next clean window -> capture_glitch[0]=0.
REQ-030 Triggers stop after RUN -> timeout=1 exactly TIMEOUT_CYCLES=6000 cycles after the last trigger; next trigger -> timeout=0 with no capture_valid; the following trigger -> capture_valid.
REQ-031 Trigger exactly at window length 6000 -> capture_valid=1, timeout stays 0.
REQ-032 Reset pulsed mid-window with pwm_in=111 -> all outputs 0 immediately; the next trigger gives no capture.
